mem_bus_ctrl: RTL and testbench

Memory-bus handshake and lane-alignment stage sitting directly downstream of the CPU's memory-access unit, between it and the Avalon-style memory bus. It latches one load/store request, holds address, byteenable and write data stable while `waitrequest` is high, and stalls the CPU for the duration. On completion it returns sign/zero-extended or LWL/LWR-merged load data with a one-cycle `done` pulse.

---
 rtl/mem_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Brief    : Memory-bus handshake and lane-alignment stage between the CPU's
//            memory-access unit and an Avalon-style bus. Latches one load or
//            store, holds the bus outputs stable under waitrequest, stalls the
//            CPU, and returns extended / LWL-LWR merged load data with a
//            one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_writedata,
    input  logic [6:0]  req_instcode,
    input  logic [31:0] reg_old,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest,
    output logic        stall,
    output logic        done,
    output logic [31:0] loaddata,
    output logic        addr_error
);

    // Instruction codes from the memory-access unit
    localparam logic [6:0] c_op_lb  = 7'd42;
    localparam logic [6:0] c_op_lbu = 7'd43;
    localparam logic [6:0] c_op_lh  = 7'd44;
    localparam logic [6:0] c_op_lhu = 7'd45;
    localparam logic [6:0] c_op_lw  = 7'd47;
    localparam logic [6:0] c_op_lwl = 7'd48;
    localparam logic [6:0] c_op_lwr = 7'd49;
    localparam logic [6:0] c_op_sb  = 7'd50;
    localparam logic [6:0] c_op_sh  = 7'd51;
    localparam logic [6:0] c_op_sw  = 7'd52;

    // Controller states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;

    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic [31:0] r_loaddata;
    logic        r_addr_error;
    logic        r_is_write;
    logic [6:0]  r_code;
    logic [1:0]  r_off;
    logic [31:0] r_old;

    logic        w_req;
    logic [1:0]  w_k;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wdata;
    logic        w_misaligned;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [4:0]  w_shl;
    logic [4:0]  w_shr;
    logic [31:0] w_load;

    assign w_req = req_read | req_write;
    assign w_k   = req_address[1:0];

    // Decode the incoming request into lane enables, lane-replicated store data
    // and the misalignment flag
    always_comb begin
        w_req_be     = 4'b1111;
        w_req_wdata  = req_writedata;
        w_misaligned = 1'b0;
        case (req_instcode)
            c_op_lb, c_op_lbu: w_req_be = 4'b0001 << w_k;
            c_op_sb: begin
                w_req_be    = 4'b0001 << w_k;
                w_req_wdata = {4{req_writedata[7:0]}};
            end
            c_op_lh, c_op_lhu: begin
                w_req_be     = w_k[1] ? 4'b1100 : 4'b0011;
                w_misaligned = w_k[0];
            end
            c_op_sh: begin
                w_req_be     = w_k[1] ? 4'b1100 : 4'b0011;
                w_req_wdata  = {2{req_writedata[15:0]}};
                w_misaligned = w_k[0];
            end
            c_op_lw, c_op_sw: w_misaligned = (w_k != 2'b00);
            default: ;
        endcase
    end

    // Load result shaping from the bus word and the latched access attributes.
    // LWL shifts left by 8*(3-k); 3-k on two bits is simply ~k.
    assign w_byte = readdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? readdata[31:16] : readdata[15:0];
    assign w_shl  = {~r_off, 3'b000};
    assign w_shr  = {r_off, 3'b000};

    // Select the processed load value for the latched instruction
    always_comb begin
        w_load = readdata;
        if (r_is_write) begin
            w_load = 32'h0;
        end else begin
            case (r_code)
                c_op_lb:  w_load = {{24{w_byte[7]}}, w_byte};
                c_op_lbu: w_load = {24'h0, w_byte};
                c_op_lh:  w_load = {{16{w_half[15]}}, w_half};
                c_op_lhu: w_load = {16'h0, w_half};
                c_op_lwl: w_load = (readdata << w_shl) | (r_old & ~(32'hFFFF_FFFF << w_shl));
                c_op_lwr: w_load = (readdata >> w_shr) | (r_old & ~(32'hFFFF_FFFF >> w_shr));
                default:  w_load = readdata;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next;
    end

    // Next-state logic; a misaligned request skips the bus entirely
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_req) w_next = w_misaligned ? c_st_done : c_st_bus;
            c_st_bus:  if (!waitrequest) w_next = c_st_done;
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    // Request latch and load result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address    <= 32'h0;
            r_byteenable <= 4'h0;
            r_writedata  <= 32'h0;
            r_loaddata   <= 32'h0;
            r_addr_error <= 1'b0;
            r_is_write   <= 1'b0;
            r_code       <= 7'h0;
            r_off        <= 2'b00;
            r_old        <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_req) begin
                        r_address    <= {req_address[31:2], 2'b00};
                        r_byteenable <= w_req_be;
                        r_writedata  <= w_req_wdata;
                        r_is_write   <= req_write;
                        r_code       <= req_instcode;
                        r_off        <= w_k;
                        r_old        <= reg_old;
                        r_addr_error <= w_misaligned;
                        r_loaddata   <= 32'h0;
                    end
                end
                c_st_bus: begin
                    if (!waitrequest) r_loaddata <= w_load;
                end
                c_st_done: r_addr_error <= 1'b0;
                default: ;
            endcase
        end
    end

    // Strobes come straight from the state register so an asynchronous reset
    // removes them without waiting for a clock edge
    assign read       = (r_state == c_st_bus) & ~r_is_write;
    assign write      = (r_state == c_st_bus) &  r_is_write;
    assign done       = (r_state == c_st_done);
    assign stall      = ((r_state == c_st_idle) & w_req) | (r_state == c_st_bus);
    assign address    = r_address;
    assign byteenable = r_byteenable;
    assign writedata  = r_writedata;
    assign loaddata   = r_loaddata;
    assign addr_error = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_ctrl
// Brief    : Directed self-checking bench for mem_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_writedata;
    logic [6:0]  req_instcode;
    logic [31:0] reg_old;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        stall;
    logic        done;
    logic [31:0] loaddata;
    logic        addr_error;

    int nvec;
    int nerr;

    mem_bus_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_writedata(req_writedata),
        .req_instcode (req_instcode),
        .reg_old      (reg_old),
        .address      (address),
        .read         (read),
        .write        (write),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .readdata     (readdata),
        .waitrequest  (waitrequest),
        .stall        (stall),
        .done         (done),
        .loaddata     (loaddata),
        .addr_error   (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a request onto the request inputs (no checking here)
    task automatic drive_req(input logic wr, input logic [6:0] code,
                             input logic [31:0] addr, input logic [31:0] d,
                             input logic [31:0] old);
        req_read      = ~wr;
        req_write     = wr;
        req_instcode  = code;
        req_address   = addr;
        req_writedata = d;
        reg_old       = old;
    endtask

    task automatic drop_req();
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drop_req();
        req_address = 0; req_writedata = 0; req_instcode = 0; reg_old = 0;
        readdata = 0; waitrequest = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if ({read, write, done, addr_error, stall} !== 5'b0) begin nerr++; $display("FAIL reset_ctl: got %b want 00000", {read, write, done, addr_error, stall}); end
        nvec++; if ({address, writedata, loaddata} !== 96'h0) begin nerr++; $display("FAIL reset_data: got %h want 0", {address, writedata, loaddata}); end
        nvec++; if (byteenable !== 4'h0) begin nerr++; $display("FAIL reset_be: got %b want 0000", byteenable); end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_lw();
        waitrequest = 1'b0;
        readdata    = 32'hDEADBEEF;
        drive_req(1'b0, 7'd47, 32'h100, 32'h0, 32'h0);            // cycle 0
        @(negedge clk);
        nvec++; if ({stall, read} !== 2'b10) begin nerr++; $display("FAIL lw_c0: stall/read got %b want 10", {stall, read}); end
        next_cycle();                                              // cycle 1
        @(negedge clk);
        nvec++; if ({read, write, stall, done} !== 4'b1010) begin nerr++; $display("FAIL lw_c1_ctl: got %b want 1010", {read, write, stall, done}); end
        nvec++; if (address !== 32'h100) begin nerr++; $display("FAIL lw_addr: got %h want 00000100", address); end
        nvec++; if (byteenable !== 4'b1111) begin nerr++; $display("FAIL lw_be: got %b want 1111", byteenable); end
        next_cycle();                                              // cycle 2
        drop_req();
        @(negedge clk);
        nvec++; if ({done, stall, read, addr_error} !== 4'b1000) begin nerr++; $display("FAIL lw_c2_ctl: got %b want 1000", {done, stall, read, addr_error}); end
        nvec++; if (loaddata !== 32'hDEADBEEF) begin nerr++; $display("FAIL lw_data: got %h want deadbeef", loaddata); end
        next_cycle();
        @(negedge clk);
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL lw_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_lb_lbu();
        logic [6:0]  codes [2];
        logic [31:0] exps  [2];
        codes[0] = 7'd42; exps[0] = 32'hFFFFFF80;
        codes[1] = 7'd43; exps[1] = 32'h00000080;
        waitrequest = 1'b0;
        readdata    = 32'h80112233;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, codes[i], 32'h103, 32'h0, 32'h0);
            next_cycle();
            @(negedge clk);
            nvec++; if (byteenable !== 4'b1000) begin nerr++; $display("FAIL lb_be[%0d]: got %b want 1000", i, byteenable); end
            nvec++; if (address !== 32'h100) begin nerr++; $display("FAIL lb_addr[%0d]: got %h want 00000100", i, address); end
            next_cycle();
            drop_req();
            @(negedge clk);
            nvec++; if ({done, addr_error} !== 2'b10) begin nerr++; $display("FAIL lb_done[%0d]: got %b want 10", i, {done, addr_error}); end
            nvec++; if (loaddata !== exps[i]) begin nerr++; $display("FAIL lb_data[%0d]: got %h want %h", i, loaddata, exps[i]); end
            next_cycle();
        end
    endtask

    task automatic test_sh_wait();
        readdata    = 32'h12345678;
        waitrequest = 1'b1;
        drive_req(1'b1, 7'd51, 32'h202, 32'h0000ABCD, 32'h0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            waitrequest = (i < 3);
            @(negedge clk);
            nvec++; if ({write, read, stall, done} !== 4'b1010) begin nerr++; $display("FAIL sh_ctl[%0d]: got %b want 1010", i, {write, read, stall, done}); end
            nvec++; if ({address, byteenable, writedata} !== {32'h200, 4'b1100, 32'hABCDABCD}) begin nerr++; $display("FAIL sh_bus[%0d]: got %h %b %h want 00000200 1100 abcdabcd", i, address, byteenable, writedata); end
        end
        next_cycle();
        drop_req();
        @(negedge clk);
        nvec++; if ({done, write, stall} !== 3'b100) begin nerr++; $display("FAIL sh_done: got %b want 100", {done, write, stall}); end
        nvec++; if (loaddata !== 32'h0) begin nerr++; $display("FAIL sh_loaddata: got %h want 0", loaddata); end
        waitrequest = 1'b0;
        next_cycle();
    endtask

    task automatic test_sb();
        waitrequest = 1'b0;
        drive_req(1'b1, 7'd50, 32'h301, 32'hFFFFFF5A, 32'h0);
        next_cycle();
        @(negedge clk);
        nvec++; if ({write, byteenable, writedata} !== {1'b1, 4'b0010, 32'h5A5A5A5A}) begin nerr++; $display("FAIL sb_bus: got %b %b %h want 1 0010 5a5a5a5a", write, byteenable, writedata); end
        next_cycle();
        drop_req();
        next_cycle();
    endtask

    task automatic test_lwl_lwr();
        logic [6:0]  codes [2];
        logic [31:0] addrs [2];
        logic [31:0] exps  [2];
        codes[0] = 7'd48; addrs[0] = 32'h401; exps[0] = 32'h2211CCDD;
        codes[1] = 7'd49; addrs[1] = 32'h402; exps[1] = 32'hAABB4433;
        waitrequest = 1'b0;
        readdata    = 32'h44332211;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b0, codes[i], addrs[i], 32'h0, 32'hAABBCCDD);
            next_cycle();
            @(negedge clk);
            nvec++; if ({read, byteenable} !== {1'b1, 4'b1111}) begin nerr++; $display("FAIL lwlr_bus[%0d]: got %b %b want 1 1111", i, read, byteenable); end
            next_cycle();
            drop_req();
            @(negedge clk);
            nvec++; if (loaddata !== exps[i]) begin nerr++; $display("FAIL lwlr_data[%0d]: got %h want %h", i, loaddata, exps[i]); end
            next_cycle();
        end
    endtask

    task automatic test_misaligned();
        waitrequest = 1'b0;
        drive_req(1'b0, 7'd47, 32'h102, 32'h0, 32'h0);
        @(negedge clk);
        nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL mis_c0_stall: got %b want 1", stall); end
        next_cycle();
        drop_req();
        @(negedge clk);
        nvec++; if ({done, addr_error, read, write, stall} !== 5'b11000) begin nerr++; $display("FAIL mis_c1: got %b want 11000", {done, addr_error, read, write, stall}); end
        next_cycle();
        @(negedge clk);
        nvec++; if ({done, addr_error, read} !== 3'b000) begin nerr++; $display("FAIL mis_after: got %b want 000", {done, addr_error, read}); end
    endtask

    task automatic test_reset_mid_bus();
        waitrequest = 1'b1;
        readdata    = 32'h80112233;
        drive_req(1'b0, 7'd47, 32'h500, 32'h0, 32'h0);
        next_cycle();
        drop_req();
        @(negedge clk);
        nvec++; if (read !== 1'b1) begin nerr++; $display("FAIL rst_bus_read: got %b want 1", read); end
        #1 reset = 1'b1;
        #1;
        nvec++; if ({read, write, done, stall} !== 4'b0000) begin nerr++; $display("FAIL rst_async: got %b want 0000", {read, write, done, stall}); end
        @(negedge clk);
        reset = 1'b0;
        waitrequest = 1'b0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            @(negedge clk);
            nvec++; if ({done, read} !== 2'b00) begin nerr++; $display("FAIL rst_no_done[%0d]: got %b want 00", i, {done, read}); end
        end
        next_cycle();
        drive_req(1'b0, 7'd43, 32'h103, 32'h0, 32'h0);
        next_cycle();
        @(negedge clk);
        nvec++; if ({read, byteenable, address} !== {1'b1, 4'b1000, 32'h100}) begin nerr++; $display("FAIL rst_next_bus: got %b %b %h want 1 1000 00000100", read, byteenable, address); end
        next_cycle();
        drop_req();
        @(negedge clk);
        nvec++; if ({done, loaddata} !== {1'b1, 32'h00000080}) begin nerr++; $display("FAIL rst_next_done: got %b %h want 1 00000080", done, loaddata); end
        next_cycle();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_wait();
        test_sb();
        test_lwl_lwr();
        test_misaligned();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
